merge_ni: RTL and testbench
===========================

MERGE_NI -- requirements
Module: merge_ni

Interface
REQ-001 Parameter: N_IN, default 4, number of input streams (legal range 2..8).
REQ-002 Parameter: D, default 220, spatial dimension of each input map.
REQ-003 Parameter: C, default 1, channels per input stream; all inputs share one C.
REQ-004 Parameter: DATA_WIDTH, default 32, pixel width in bits.
REQ-005 Parameter: MODE, default 0; 0 = block concatenation, 1 = element interleave.
REQ-006 Derived constant: T = D*D*C words per input; total buffer is N_IN*T words.
REQ-007 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-008 Port: reset  input  1  asynchronous, active-low; clears all state.
REQ-009 Port: valid_in  input  N_IN  per-stream beat valid.
REQ-010 Port: pxl_in  input  N_IN*DATA_WIDTH  packed pixels; stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port: ready_in  output  N_IN  per-stream accept signal.
REQ-012 Port: pxl_out  output  DATA_WIDTH  merged pixel.
REQ-013 Port: valid_out  output  1  pxl_out holds a valid word.
REQ-014 Port: ready_out  input  1  downstream accept.
REQ-015 Port: frame_done  output  1  one-cycle pulse on acceptance of the last output word.
REQ-016 Port: busy  output  1  high while in DRAIN.

Function
REQ-017 The block SHALL have two states: FILL and DRAIN; it SHALL leave reset in FILL.
REQ-018 In FILL, ready_in[i] SHALL equal (wr_cnt[i] < T), combinationally; in DRAIN, ready_in SHALL be all zeros.
REQ-019 A beat on stream i SHALL be accepted when valid_in[i] && ready_in[i]; the word SHALL be written to slot i*T + wr_cnt[i], and wr_cnt[i] SHALL increment.
REQ-020 Streams SHALL be accepted independently; simultaneous beats on any subset of streams in one cycle SHALL all be stored.
REQ-021 Beats presented while ready_in[i]=0 SHALL be ignored, with no memory or counter change.
REQ-022 FILL->DRAIN SHALL occur on the edge after the one on which every wr_cnt[i] equals T.
REQ-023 The first output word SHALL appear with valid_out=1 on the edge after DRAIN is entered, giving a latency of 2 cycles from the final input beat.
REQ-024 MODE 0 output order: stream 0 words 0..T-1, then stream 1, ..., then stream N_IN-1.
REQ-025 MODE 1 output order: word 0 of streams 0..N_IN-1, then word 1 of streams 0..N_IN-1, ..., up to word T-1.
REQ-026 The output SHALL be a registered stage that loads the next word when !valid_out || ready_out; while valid_out && !ready_out, pxl_out and valid_out SHALL hold stable.
REQ-027 Exactly N_IN*T words SHALL be emitted per frame, with no duplicates or gaps; valid_out SHALL fall after the last word is accepted unless a new word is loaded.
REQ-028 On acceptance of the last word, frame_done SHALL pulse high for one cycle, all wr_cnt values and read pointers SHALL clear, and the state SHALL return to FILL on that same edge.
REQ-029 ready_in SHALL be able to reassert in the cycle following frame_done.
REQ-030 Counter widths SHALL be clog2(N_IN*T+1) bits; no pointer SHALL wrap within a frame.

Reset
REQ-031 While reset=0: state=FILL, wr_cnt=0, read pointer=0, valid_out=0, pxl_out=0, frame_done=0, busy=0, and ready_in all ones once reset is released.
REQ-032 Assertion of reset mid-FILL or mid-DRAIN SHALL discard the buffered frame immediately (asynchronously) and emit no further words.
REQ-033 Memory contents need not be cleared by reset.

Verification
REQ-034 N_IN=4, D=2, C=1, W=8, MODE 0; stream i sends 8'h(i0..i3) with ready_out=1 -> output 00,01,02,03,10,...,33 (16 words), first valid 2 cycles after the final beat, frame_done on word 33.
REQ-035 Same data, MODE 1 -> output 00,10,20,30,01,11,...,33.
REQ-036 Stream 0 completes 4 beats while streams 1-3 are idle; stream 0 then asserts a 5th beat -> ready_in[0]=0 and the 5th beat is dropped; no DRAIN until all streams reach 4.
REQ-037 In MODE 0, ready_out toggles 1,0,0,1 repeatedly -> pxl_out is held stable through the stalls, the sequence is unchanged, and exactly 16 words are emitted.
REQ-038 reset is pulsed low after 6 words of DRAIN -> valid_out=0 at once, ready_in=4'hF after release, and a following fresh frame drains correctly from word 00.
REQ-039 Back-to-back frames: new inputs are driven the cycle after frame_done -> the second frame is accepted and drained in the correct order with no stale words.

Source files
------------

// File: rtl/merge_ni.sv
`default_nettype none
// ============================================================================
// Module   : merge_ni
// Purpose  : Buffers one full frame from N_IN pixel streams, then emits it as
//            block-concatenated (MODE 0) or element-interleaved (MODE 1) words.
// Revision : 1.0
// ============================================================================
module merge_ni #(
  parameter int N_IN       = 4,
  parameter int D          = 220,
  parameter int C          = 1,
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN-1:0]            valid_in,
  input  logic [N_IN*DATA_WIDTH-1:0] pxl_in,
  output logic [N_IN-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]      pxl_out,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int T     = D * D * C;
  localparam int TOTAL = N_IN * T;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int MW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CW-1:0] T_C     = CW'(T);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [MW-1:0] T_M     = MW'(T);
  localparam logic [SW-1:0] S_LAST  = SW'(N_IN - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           wr_cnt_q [N_IN];
  logic [CW-1:0]           wr_cnt_d [N_IN];
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [SW-1:0]           rd_s_q, rd_s_d;
  logic [MW-1:0]           rd_w_q, rd_w_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0]   pxl_out_q, pxl_out_d;

  logic [DATA_WIDTH-1:0]   mem [TOTAL];

  logic [N_IN-1:0]         accept;
  logic [MW-1:0]           wr_addr [N_IN];
  logic [MW-1:0]           rd_addr;
  logic                    all_full;
  logic                    load;
  logic                    last_take;

  // Per-stream acceptance; each stream owns the slot range [i*T, i*T+T-1].
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      ready_in[i] = (state_q == FILL) && (wr_cnt_q[i] < T_C);
      accept[i]   = valid_in[i] && ready_in[i];
      wr_addr[i]  = MW'(i * T) + wr_cnt_q[i][MW-1:0];
      if (wr_cnt_q[i] != T_C) begin
        all_full = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (accept[i]) begin
        mem[wr_addr[i]] <= pxl_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Interleave walks stream index fastest, word index slowest.
  assign rd_addr = (MODE == 1) ? (MW'(rd_s_q) * T_M + rd_w_q) : rd_cnt_q[MW-1:0];

  assign load      = (state_q == DRAIN) && (rd_cnt_q != TOTAL_C) && (!valid_out_q || ready_out);
  assign last_take = (state_q == DRAIN) && valid_out_q && ready_out && (rd_cnt_q == TOTAL_C);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_s_d   = rd_s_q;
    rd_w_d   = rd_w_q;
    for (int i = 0; i < N_IN; i++) begin
      wr_cnt_d[i] = wr_cnt_q[i];
    end
    case (state_q)
      FILL: begin
        for (int i = 0; i < N_IN; i++) begin
          if (accept[i]) begin
            wr_cnt_d[i] = wr_cnt_q[i] + CW'(1);
          end
        end
        if (all_full) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (load) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_s_q == S_LAST) begin
            rd_s_d = '0;
            rd_w_d = rd_w_q + MW'(1);
          end else begin
            rd_s_d = rd_s_q + SW'(1);
          end
        end
        if (last_take) begin
          state_d  = FILL;
          rd_cnt_d = '0;
          rd_s_d   = '0;
          rd_w_d   = '0;
          for (int i = 0; i < N_IN; i++) begin
            wr_cnt_d[i] = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output register: refills whenever empty or being consumed, otherwise holds.
  always_comb begin
    valid_out_d = valid_out_q;
    pxl_out_d   = pxl_out_q;
    if (load) begin
      valid_out_d = 1'b1;
      pxl_out_d   = mem[rd_addr];
    end else if (ready_out) begin
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      rd_cnt_q    <= '0;
      rd_s_q      <= '0;
      rd_w_q      <= '0;
      valid_out_q <= 1'b0;
      pxl_out_q   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        wr_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_s_q      <= rd_s_d;
      rd_w_q      <= rd_w_d;
      valid_out_q <= valid_out_d;
      pxl_out_q   <= pxl_out_d;
      for (int i = 0; i < N_IN; i++) begin
        wr_cnt_q[i] <= wr_cnt_d[i];
      end
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = last_take;
  assign busy       = (state_q == DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_merge_ni.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge_ni
// Purpose  : Directed checks of merge_ni in both output modes (N_IN=4, D=2, W=8).
// Revision : 1.0
// ============================================================================
module tb_merge_ni;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid_in;
  logic [31:0] pxl_in;
  logic        ready_out;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  pxl0, pxl1;
  logic        v0, v1, fd0, fd1, busy0, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  merge_ni #(.N_IN(4), .D(2), .C(1), .DATA_WIDTH(8), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_in(rdy0), .pxl_out(pxl0), .valid_out(v0), .ready_out(ready_out),
    .frame_done(fd0), .busy(busy0)
  );

  merge_ni #(.N_IN(4), .D(2), .C(1), .DATA_WIDTH(8), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_in(rdy1), .pxl_out(pxl1), .valid_out(v1), .ready_out(ready_out),
    .frame_done(fd1), .busy(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word k of stream i carries {i+hi, k} in its two nibbles.
  function automatic logic [31:0] pack(input int hi, input int k);
    logic [31:0] p;
    for (int i = 0; i < 4; i++) p[i*8 +: 8] = 8'(((i + hi) << 4) | k);
    return p;
  endfunction

  function automatic logic [7:0] exp_m0(input int n, input int hi);
    return 8'((((n / 4) + hi) << 4) | (n % 4));
  endfunction

  function automatic logic [7:0] exp_m1(input int n, input int hi);
    return 8'((((n % 4) + hi) << 4) | (n / 4));
  endfunction

  task automatic send_frame(input int hi, input bit skip_first_wait);
    for (int k = 0; k < 4; k++) begin
      if (!(k == 0 && skip_first_wait)) @(negedge clk);
      if (k == 0 && skip_first_wait) begin
        valid_in = 4'hF;
      end else begin
        #1;
        check_val("fill_ready0", rdy0, 4'hF);
        check_val("fill_ready1", rdy1, 4'hF);
        valid_in = 4'hF;
      end
      pxl_in = pack(hi, k);
    end
  endtask

  // pat 0: ready_out always 1; pat 1: ready_out cycles 1,0,0,1.
  task automatic drain(input int pat, input int hi, input bit lat_chk, input int stop_after);
    int       n0, n1, first_cyc;
    bit       st0, st1;
    logic [7:0] h0, h1;
    n0 = 0; n1 = 0; st0 = 0; st1 = 0; first_cyc = -1; h0 = '0; h1 = '0;
    for (int cyc = 0; cyc < 200 && (n0 < stop_after || n1 < stop_after); cyc++) begin
      @(negedge clk);
      valid_in  = 4'h0;
      ready_out = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (st0) begin
        check_val("hold_valid0", v0, 1'b1);
        check_val("hold_data0", pxl0, h0);
      end
      if (st1) begin
        check_val("hold_valid1", v1, 1'b1);
        check_val("hold_data1", pxl1, h1);
      end
      if (v0 && first_cyc < 0) first_cyc = cyc;
      if (v0 && ready_out) begin
        check_val("m0_word", pxl0, exp_m0(n0, hi));
        check_val("m0_done", fd0, (n0 == 15));
        n0++;
      end
      if (v1 && ready_out) begin
        check_val("m1_word", pxl1, exp_m1(n1, hi));
        check_val("m1_done", fd1, (n1 == 15));
        n1++;
      end
      st0 = v0 && !ready_out; h0 = pxl0;
      st1 = v1 && !ready_out; h1 = pxl1;
    end
    check_val("m0_count", n0, stop_after);
    check_val("m1_count", n1, stop_after);
    if (lat_chk) check_val("latency", first_cyc, 2);
  endtask

  task automatic post_check();
    @(negedge clk);
    #1;
    check_val("end_valid0", v0, 1'b0);
    check_val("end_valid1", v1, 1'b0);
    check_val("end_done0", fd0, 1'b0);
    check_val("end_busy0", busy0, 1'b0);
    check_val("end_ready0", rdy0, 4'hF);
    check_val("end_ready1", rdy1, 4'hF);
  endtask

  initial begin
    reset     = 1'b0;
    valid_in  = 4'h0;
    pxl_in    = '0;
    ready_out = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_valid", v0, 1'b0);
    check_val("rst_pxl", pxl0, 8'h00);
    check_val("rst_done", fd0, 1'b0);
    check_val("rst_busy", busy0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_ready0", rdy0, 4'hF);
    check_val("rst_ready1", rdy1, 4'hF);

    // Basic frame in both modes, with latency check.
    send_frame(0, 1'b0);
    drain(0, 0, 1'b1, 16);
    post_check();

    // Stream 0 fills alone; an extra beat must be dropped.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      valid_in = 4'b0001;
      pxl_in   = pack(0, k);
    end
    @(negedge clk);
    valid_in = 4'b0001;
    pxl_in   = 32'h000000EE;
    #1;
    check_val("over_ready", rdy0, 4'hE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_in = 4'h0;
      #1;
      check_val("over_busy", busy0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      valid_in = 4'b1110;
      pxl_in   = pack(0, k);
    end
    drain(0, 0, 1'b1, 16);
    post_check();

    // Backpressure pattern.
    send_frame(2, 1'b0);
    drain(1, 2, 1'b0, 16);
    post_check();

    // Reset after six drained words, then a fresh frame.
    send_frame(3, 1'b0);
    drain(0, 3, 1'b0, 6);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_valid0", v0, 1'b0);
    check_val("midrst_valid1", v1, 1'b0);
    check_val("midrst_busy", busy0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_ready", rdy0, 4'hF);
    send_frame(0, 1'b0);
    drain(0, 0, 1'b1, 16);
    post_check();

    // Back-to-back: next frame driven in the cycle after frame_done.
    send_frame(8, 1'b1);
    drain(0, 8, 1'b1, 16);
    post_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
